// File: rtl/hamming_secded_decoder_if.sv
// Request/acknowledge handshake plus shared data-memory byte port used by
// the SECDED decoder stage.
//   req          start pulse from the core
//   ack          decoder finished, held until the next request
//   mem_addr     data-memory byte address
//   mem_rd_data  synchronous read data, valid one cycle after mem_addr
//   mem_wr_en    byte write strobe
//   mem_wr_data  byte write data
// master: the decoder side. slave: the core/memory side.
interface hamming_secded_decoder_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;

  modport master (
    input  req, mem_rd_data,
    output ack, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    output req, mem_rd_data,
    input  ack, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Hamming SECDED decoder stage. On a request it walks NUM_WORDS 16-bit
// encoded words (byte pairs at SRC_BASE), corrects single-bit errors, flags
// double-bit errors and writes 11-bit messages plus 2-bit status as byte
// pairs to DST_BASE, then raises ack.
//   clock     system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       handshake + shared data-memory port (master side)
//   err1_cnt  words corrected in this run (saturates at 31)
//   err2_cnt  double-error words in this run (saturates at 31)
module hamming_secded_decoder #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  hamming_secded_decoder_if.master bus,
  output logic [4:0]               err1_cnt,
  output logic [4:0]               err2_cnt
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE
  } state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic              last;
  logic              start;
  logic [ADDR_W-1:0] word_off, src_addr, dst_addr;
  logic [7:0]        lo_byte_p0, hi_byte_p0;
  logic [15:0]       dec_word, dec_word_p1;

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c == 5'd31) ? c : c + 5'd1;
  endfunction

  // Returns {flags[1:0], 3'b000, d11..d9, d8..d1}. Masks select positions
  // 1..15 whose index has bit k set; position 0 (p0) only enters parity.
  function automatic logic [15:0] decode_word(input logic [15:0] w);
    logic [3:0]  s;
    logic        p;
    logic [15:0] c;
    logic [1:0]  f;
    s[0] = ^(w & 16'hAAAA);
    s[1] = ^(w & 16'hCCCC);
    s[2] = ^(w & 16'hF0F0);
    s[3] = ^(w & 16'hFF00);
    p    = ^w;
    c    = w;
    f    = 2'b00;
    if (p) begin
      f = 2'b01;
      if (s != 4'd0) c = w ^ (16'd1 << s);
    end else if (s != 4'd0) begin
      f = 2'b10;
    end
    return {f, 3'b000, c[15], c[14], c[13],
            c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
  endfunction

  assign last     = (idx == IDX_W'(NUM_WORDS - 1));
  assign start    = ((state == IDLE) || (state == DONE)) && bus.req;
  assign word_off = ADDR_W'({idx, 1'b0});
  assign src_addr = ADDR_W'(SRC_BASE) + word_off;
  assign dst_addr = ADDR_W'(DST_BASE) + word_off;
  assign dec_word = decode_word({hi_byte_p0, lo_byte_p0});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      err1_cnt <= '0;
      err2_cnt <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        idx      <= '0;
        err1_cnt <= '0;
        err2_cnt <= '0;
      end else begin
        if (state == WR_HI && !last) idx <= idx + 1'b1;
        if (state == DEC) begin
          if (dec_word[14]) err1_cnt <= sat_inc(err1_cnt);
          if (dec_word[15]) err2_cnt <= sat_inc(err2_cnt);
        end
      end
    end
  end

  // Stage p0: encoded bytes captured from memory (low in RD_HI, high in CAP)
  always_ff @(posedge clock) begin
    if (state == RD_HI) lo_byte_p0 <= bus.mem_rd_data;
    if (state == CAP)   hi_byte_p0 <= bus.mem_rd_data;
  end

  // Stage p1: decoded output byte pair held through WR_LO/WR_HI
  always_ff @(posedge clock) begin
    if (state == DEC) dec_word_p1 <= dec_word;
  end

  always_comb begin
    state_next      = state;
    bus.ack         = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    case (state)
      IDLE:  if (bus.req) state_next = RD_LO;
      RD_LO: begin
        bus.mem_addr = src_addr;
        state_next   = RD_HI;
      end
      RD_HI: begin
        bus.mem_addr = src_addr + ADDR_W'(1);
        state_next   = CAP;
      end
      CAP:   state_next = DEC;
      DEC:   state_next = WR_LO;
      WR_LO: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_addr    = dst_addr;
        bus.mem_wr_data = dec_word_p1[7:0];
        state_next      = WR_HI;
      end
      WR_HI: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_addr    = dst_addr + ADDR_W'(1);
        bus.mem_wr_data = dec_word_p1[15:8];
        state_next      = last ? DONE : RD_LO;
      end
      DONE: begin
        bus.ack = 1'b1;
        if (bus.req) state_next = RD_LO;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
module tb_hamming_secded_decoder;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] err1_cnt, err2_cnt;

  hamming_secded_decoder_if #(.ADDR_W(8)) bif ();

  hamming_secded_decoder #(
    .NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bif),
    .err1_cnt(err1_cnt),
    .err2_cnt(err2_cnt)
  );

  always #5 clock = ~clock;

  logic [7:0] src_mem [0:255];
  logic [7:0] wr_mem  [0:255];
  int         hits    [0:255];
  int         bad_wr = 0;
  int         cyc = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    bif.mem_rd_data <= src_mem[bif.mem_addr];
    if (bif.mem_wr_en === 1'b1) begin
      wr_mem[bif.mem_addr] <= bif.mem_wr_data;
      hits[bif.mem_addr]   <= hits[bif.mem_addr] + 1;
      if (bif.mem_addr >= 8'd30) bad_wr <= bad_wr + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_lo [NW];
  logic [7:0] exp_hi [NW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] w;
    logic        par;
    w = '0;
    for (int j = 0; j < 11; j++) w[DPOS[j]] = m[j];
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++) if ((p & (1 << k)) != 0) par ^= w[p];
      w[1 << k] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] m;
    for (int j = 0; j < 11; j++) m[j] = w[DPOS[j]];
    return m;
  endfunction

  task automatic load_word(input int i, input logic [15:0] w);
    src_mem[SRC + 2*i]     = w[7:0];
    src_mem[SRC + 2*i + 1] = w[15:8];
  endtask

  task automatic pulse_req(output int t0);
    @(negedge clock);
    bif.req = 1'b1;
    @(posedge clock);
    #1;
    t0 = cyc;
    bif.req = 1'b0;
  endtask

  task automatic wait_ack(input int t0, output int lat);
    int k;
    k = 0;
    while (bif.ack !== 1'b1 && k < 300) begin
      @(posedge clock);
      #1;
      k++;
    end
    lat = cyc - t0;
  endtask

  task automatic check_outputs(input string run);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("%s_w%0d_lo", run, i), wr_mem[DST + 2*i], exp_lo[i]);
      chk($sformatf("%s_w%0d_hi", run, i), wr_mem[DST + 2*i + 1], exp_hi[i]);
    end
  endtask

  initial begin
    int          t0, lat, k, h14, h15, e1, e2, nflip, p1, p2;
    logic [10:0] msg;
    logic [15:0] cw;

    reset_n = 1'b0;
    bif.req = 1'b0;
    #1;
    chk("rst_addr", bif.mem_addr, 0);
    chk("rst_wr_en", bif.mem_wr_en, 0);
    chk("rst_wr_data", bif.mem_wr_data, 0);
    chk("rst_ack", bif.ack, 0);
    chk("rst_err1", err1_cnt, 0);
    chk("rst_err2", err2_cnt, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Run 1: hand vectors (clean, d11 flip, p0 flip, double, all-ones)
    load_word(0, 16'h000F);
    load_word(1, 16'h800F);
    load_word(2, 16'h000E);
    load_word(3, 16'hC00F);
    load_word(4, 16'hFFFF);
    for (int i = 5; i < NW; i++) load_word(i, 16'h0000);
    exp_lo = '{8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_hi = '{8'h00, 8'h40, 8'h40, 8'h86, 8'h07, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_req(t0);
    wait_ack(t0, lat);
    chk("run1_ack", bif.ack, 1);
    chk("run1_latency", lat, 90);
    check_outputs("run1");
    chk("run1_err1", err1_cnt, 2);
    chk("run1_err2", err2_cnt, 1);

    // Run 2: random messages with 0/1/2 flipped bits
    e1 = 0;
    e2 = 0;
    for (int i = 0; i < NW; i++) begin
      msg   = 11'($urandom_range(0, 2047));
      cw    = encode(msg);
      nflip = i % 3;
      p1    = $urandom_range(0, 15);
      p2    = (p1 + 1 + $urandom_range(0, 14)) % 16;
      if (nflip >= 1) cw[p1] = ~cw[p1];
      if (nflip == 2) cw[p2] = ~cw[p2];
      load_word(i, cw);
      if (nflip == 2) begin
        exp_lo[i] = extract(cw)[7:0];
        exp_hi[i] = {2'b10, 3'b000, extract(cw)[10:8]};
        e2++;
      end else begin
        exp_lo[i] = msg[7:0];
        exp_hi[i] = {(nflip == 1) ? 2'b01 : 2'b00, 3'b000, msg[10:8]};
        if (nflip == 1) e1++;
      end
    end
    pulse_req(t0);
    wait_ack(t0, lat);
    chk("run2_ack", bif.ack, 1);
    chk("run2_latency", lat, 90);
    check_outputs("run2");
    chk("run2_err1", err1_cnt, e1);
    chk("run2_err2", err2_cnt, e2);

    // Run 3: reset during word 7 WR_LO
    pulse_req(t0);
    k = 0;
    while (!(bif.mem_wr_en === 1'b1 && bif.mem_addr === 8'(DST + 14)) && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("reach_w7_wr_lo", (bif.mem_wr_en === 1'b1 && bif.mem_addr === 8'(DST + 14)), 1);
    h14 = hits[DST + 14];
    h15 = hits[DST + 15];
    reset_n = 1'b0;
    #1;
    chk("abort_addr", bif.mem_addr, 0);
    chk("abort_wr_en", bif.mem_wr_en, 0);
    chk("abort_wr_data", bif.mem_wr_data, 0);
    chk("abort_ack", bif.ack, 0);
    chk("abort_err1", err1_cnt, 0);
    chk("abort_err2", err2_cnt, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("abort_no_wr_lo", hits[DST + 14], h14);
    chk("abort_no_wr_hi", hits[DST + 15], h15);
    @(negedge clock);
    reset_n = 1'b1;

    // Run 4: rerun from word 0 with a req pulse mid-run
    pulse_req(t0);
    repeat (20) @(posedge clock);
    @(negedge clock);
    bif.req = 1'b1;
    @(negedge clock);
    bif.req = 1'b0;
    wait_ack(t0, lat);
    chk("run4_ack", bif.ack, 1);
    chk("run4_latency", lat, 90);
    check_outputs("run4");
    chk("run4_w7_hi_written", hits[DST + 15], h15 + 1);
    chk("run4_err1", err1_cnt, e1);
    chk("run4_err2", err2_cnt, e2);
    repeat (5) @(posedge clock);
    #1;
    chk("done_hold_ack", bif.ack, 1);

    // Run 5: second req in DONE restarts with counters cleared
    pulse_req(t0);
    chk("restart_ack", bif.ack, 0);
    chk("restart_err1", err1_cnt, 0);
    chk("restart_err2", err2_cnt, 0);
    wait_ack(t0, lat);
    chk("run5_latency", lat, 90);
    chk("run5_err1", err1_cnt, e1);
    chk("run5_err2", err2_cnt, e2);
    chk("no_wr_at_src", bad_wr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
